// File: rtl/cm_ram_port_arbiter.sv
// Round-robin arbiter sharing one cm_ram port among NUM requesters.
// Registered command stage; read data is steered back by a one-hot tag pipeline.
module cm_ram_port_arbiter #(
    parameter int NUM    = 4,
    parameter int ASIZE  = 12,
    parameter int DSIZE  = 36,
    parameter int RD_LAT = 3
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [NUM-1:0]         req_vld,
    input  logic [NUM-1:0]         req_wr,
    input  logic [NUM*ASIZE-1:0]   req_addr,
    input  logic [NUM*DSIZE-1:0]   req_wdata,
    output logic [NUM-1:0]         req_rdy,
    output logic [NUM-1:0]         rsp_vld,
    output logic [DSIZE-1:0]       rsp_data,
    output logic [ASIZE-1:0]       ram_addr,
    output logic [DSIZE-1:0]       ram_din,
    output logic                   ram_we,
    input  logic [DSIZE-1:0]       ram_dout
);

    localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [PW-1:0]      r_ptr;
    logic [ASIZE-1:0]   r_ram_addr;
    logic [DSIZE-1:0]   r_ram_din;
    logic               r_ram_we;
    logic [NUM-1:0]     r_tag [0:RD_LAT];

    logic [2*NUM-1:0]   w_dbl;
    logic [NUM-1:0]     w_grant;
    logic               w_found;
    logic [PW-1:0]      w_gidx;
    logic               w_sel_wr;
    logic [ASIZE-1:0]   w_sel_addr;
    logic [DSIZE-1:0]   w_sel_wdata;

    // Rotate the request vector so the slot after the pointer sits at bit 0, then pick the lowest set bit.
    always_comb begin
        int v_base;
        int v_win;
        v_base      = int'(r_ptr) + 1;
        v_win       = -1;
        w_dbl       = {req_vld, req_vld} >> v_base;
        w_grant     = '0;
        w_found     = 1'b0;
        w_gidx      = '0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int j = NUM - 1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                v_win = (v_base + j) % NUM;
            end else begin
                v_win = v_win;
            end
        end
        for (int i = 0; i < NUM; i++) begin
            if (i == v_win) begin
                w_grant[i]  = 1'b1;
                w_found     = 1'b1;
                w_gidx      = PW'(i);
                w_sel_wr    = req_wr[i];
                w_sel_addr  = req_addr[i*ASIZE +: ASIZE];
                w_sel_wdata = req_wdata[i*DSIZE +: DSIZE];
            end else begin
                w_grant[i]  = 1'b0;
            end
        end
    end

    // Command register and round-robin pointer; address/data hold on idle cycles.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= PW'(NUM - 1);
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_we   <= 1'b0;
        end else if (w_found) begin
            r_ptr      <= w_gidx;
            r_ram_addr <= w_sel_addr;
            r_ram_din  <= w_sel_wdata;
            r_ram_we   <= w_sel_wr;
        end else begin
            r_ram_we   <= 1'b0;
        end
    end

    // Read-tag pipeline: stage RD_LAT lines up with ram_dout for the matching command.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= RD_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= (w_found && !w_sel_wr) ? w_grant : '0;
            for (int s = 1; s <= RD_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign req_rdy  = w_grant;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign ram_we   = r_ram_we;
    assign rsp_vld  = r_tag[RD_LAT];
    assign rsp_data = ram_dout;

endmodule

// File: tb/tb_cm_ram_port_arbiter.sv
// Bench for cm_ram_port_arbiter: behavioural RAM, request programs per requester,
// and a transaction-level model (rotation rule, memory map, response schedule).
module tb_cm_ram_port_arbiter;

    localparam int NUM    = 4;
    localparam int ASIZE  = 12;
    localparam int DSIZE  = 36;
    localparam int RD_LAT = 3;

    logic                 clock;
    logic                 rst_n;
    logic [NUM-1:0]       req_vld;
    logic [NUM-1:0]       req_wr;
    logic [NUM*ASIZE-1:0] req_addr;
    logic [NUM*DSIZE-1:0] req_wdata;
    logic [NUM-1:0]       req_rdy;
    logic [NUM-1:0]       rsp_vld;
    logic [DSIZE-1:0]     rsp_data;
    logic [ASIZE-1:0]     ram_addr;
    logic [DSIZE-1:0]     ram_din;
    logic                 ram_we;
    logic [DSIZE-1:0]     ram_dout;

    cm_ram_port_arbiter #(.NUM(NUM), .ASIZE(ASIZE), .DSIZE(DSIZE), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .rst_n(rst_n),
        .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DSIZE-1:0] init_val(input logic [ASIZE-1:0] a);
        return {12'hC5A, a, ~a};
    endfunction

    // RAM: output register, wrapper register and one more stage give RD_LAT = 3.
    logic [DSIZE-1:0] ram_mem [4096];
    logic [DSIZE-1:0] rd_p1, rd_p2, rd_p3;
    bit               ram_ready = 1'b0;
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int a = 0; a < 4096; a++) ram_mem[a] <= init_val(12'(a));
            ram_ready <= 1'b1;
        end else begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            rd_p1 <= ram_mem[ram_addr];
            rd_p2 <= rd_p1;
            rd_p3 <= rd_p2;
        end
    end
    assign ram_dout = rd_p3;

    typedef struct packed { logic wr; logic [ASIZE-1:0] addr; logic [DSIZE-1:0] data; } cmd_t;
    typedef struct { int due; logic [NUM-1:0] g; logic [DSIZE-1:0] d; } rsp_t;

    cmd_t             prog [NUM][8];
    int               prog_n [NUM];
    int               prog_i [NUM];
    int               prog_st [NUM];
    rsp_t             rq [$];
    logic [DSIZE-1:0] mm [logic [ASIZE-1:0]];
    int               m_ptr;
    logic [NUM-1:0]   m_gnt;
    logic             m_we;
    logic [ASIZE-1:0] m_addr;
    logic [DSIZE-1:0] m_din;
    int               cyc;
    int               n_chk;
    int               n_fail;
    int               rsp_cnt [NUM];

    function automatic logic [DSIZE-1:0] mem_val(input logic [ASIZE-1:0] a);
        if (mm.exists(a)) return mm[a];
        return init_val(a);
    endfunction

    task automatic check(input string nm, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model past the coming edge.
    task automatic compare();
        logic [NUM-1:0]   eg;
        logic [NUM-1:0]   ev;
        logic [DSIZE-1:0] ed;
        logic [ASIZE-1:0] a;
        int               gi;
        rsp_t             e;
        if (!rst_n) begin
            check("rst_ram_we", 36'(ram_we), 36'(0));
            check("rst_rsp_vld", 36'(rsp_vld), 36'(0));
            m_we = 1'b0; m_addr = '0; m_din = '0; m_ptr = NUM - 1; m_gnt = '0;
            rq.delete();
            return;
        end
        gi = -1;
        for (int k = 1; k <= NUM; k++) begin
            if (gi < 0 && req_vld[(m_ptr + k) % NUM]) gi = (m_ptr + k) % NUM;
        end
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        check("req_rdy", 36'(req_rdy), 36'(eg));
        check("ram_we", 36'(ram_we), 36'(m_we));
        check("ram_addr", 36'(ram_addr), 36'(m_addr));
        if (m_we) check("ram_din", ram_din, m_din);
        ev = '0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev = rq[0].g; ed = rq[0].d;
            void'(rq.pop_front());
        end
        check("rsp_vld", 36'(rsp_vld), 36'(ev));
        if (ev != '0) check("rsp_data", rsp_data, ed);
        for (int i = 0; i < NUM; i++) if (rsp_vld[i]) rsp_cnt[i]++;
        m_gnt = eg;
        m_we  = 1'b0;
        if (gi >= 0) begin
            m_ptr  = gi;
            a      = req_addr[gi*ASIZE +: ASIZE];
            m_addr = a;
            if (req_wr[gi]) begin
                m_we  = 1'b1;
                m_din = req_wdata[gi*DSIZE +: DSIZE];
                mm[a] = m_din;
            end else begin
                e.due = cyc + 1 + RD_LAT; e.g = eg; e.d = mem_val(a);
                rq.push_back(e);
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM; i++) begin
            if (prog_i[i] < prog_n[i] && cyc >= prog_st[i]) begin
                req_vld[i] = 1'b1;
                req_wr[i]  = prog[i][prog_i[i]].wr;
                req_addr[i*ASIZE +: ASIZE]  = prog[i][prog_i[i]].addr;
                req_wdata[i*DSIZE +: DSIZE] = prog[i][prog_i[i]].data;
            end else begin
                req_vld[i] = 1'b0;
                req_wr[i]  = 1'b0;
            end
        end
    endtask

    task automatic to_negedge();
        @(negedge clock);
        compare();
    endtask

    task automatic to_next();
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < NUM; i++) if (m_gnt[i]) prog_i[i]++;
        drive();
    endtask

    task automatic tick();
        to_negedge();
        to_next();
    endtask

    task automatic clear_progs();
        for (int i = 0; i < NUM; i++) begin
            prog_n[i] = 0; prog_i[i] = 0; prog_st[i] = 0;
        end
    endtask

    task automatic set_cmd(input int r, input int k, input logic wr, input logic [ASIZE-1:0] a,
                           input logic [DSIZE-1:0] d, input int st);
        prog[r][k].wr = wr; prog[r][k].addr = a; prog[r][k].data = d;
        if (prog_n[r] < k + 1) prog_n[r] = k + 1;
        prog_st[r] = st;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_progs();
        drive();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_at(input int t, input logic [NUM-1:0] v, input logic [DSIZE-1:0] d, input string nm);
        while (cyc < t) tick();
        to_negedge();
        check({nm, "_vld"}, 36'(rsp_vld), 36'(v));
        check({nm, "_data"}, rsp_data, d);
        to_next();
    endtask

    logic [NUM-1:0] t4_exp [6];
    logic [NUM-1:0] exp_g;
    int             t0;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        m_ptr = NUM - 1; m_gnt = '0; m_we = 1'b0; m_addr = '0; m_din = '0;
        clear_progs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset release.
        for (int k = 0; k < 20; k++) begin
            to_negedge();
            check("idle_rdy", 36'(req_rdy), 36'(0));
            to_next();
        end

        // Write then read of the same address by requester 0.
        do_reset();
        set_cmd(0, 0, 1'b1, 12'h010, 36'h5A5A5A5A5, cyc);
        set_cmd(0, 1, 1'b0, 12'h010, 36'h0, cyc);
        drive();
        t0 = cyc;
        tick();
        to_negedge();
        check("t2_we", 36'(ram_we), 36'(1));
        check("t2_addr", 36'(ram_addr), 36'h010);
        check("t2_din", ram_din, 36'h5A5A5A5A5);
        to_next();
        expect_at(t0 + 2 + RD_LAT, 4'b0001, 36'h5A5A5A5A5, "t2_rsp");

        // All four requesters read continuously.
        do_reset();
        for (int i = 0; i < NUM; i++) begin
            rsp_cnt[i] = 0;
            for (int k = 0; k < 4; k++) set_cmd(i, k, 1'b0, 12'(12'h020 + i * 4 + k), 36'h0, cyc);
        end
        drive();
        for (int k = 0; k < 16; k++) begin
            to_negedge();
            exp_g = 4'b0001 << (k % 4);
            check("t3_grant", 36'(req_rdy), 36'(exp_g));
            to_next();
        end
        repeat (RD_LAT + 3) tick();
        for (int i = 0; i < NUM; i++) check("t3_rsp_count", 36'(rsp_cnt[i]), 36'(4));

        // Requesters 1 and 3, with 2 arriving mid-stream.
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 5; k++) set_cmd(1, k, 1'b0, 12'(12'h300 + k), 36'h0, t0);
        for (int k = 0; k < 4; k++) set_cmd(3, k, 1'b0, 12'(12'h310 + k), 36'h0, t0 + 1);
        set_cmd(2, 0, 1'b0, 12'h320, 36'h0, t0 + 3);
        drive();
        t4_exp[0] = 4'b0010; t4_exp[1] = 4'b1000; t4_exp[2] = 4'b0010;
        t4_exp[3] = 4'b0100; t4_exp[4] = 4'b1000; t4_exp[5] = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            to_negedge();
            check("t4_grant", 36'(req_rdy), 36'(t4_exp[k]));
            to_next();
        end
        repeat (12) tick();

        // Interleaved writes (req2) and reads (req0).
        do_reset();
        t0 = cyc;
        set_cmd(0, 0, 1'b0, 12'h200, 36'h0, t0);
        set_cmd(0, 1, 1'b0, 12'h100, 36'h0, t0);
        set_cmd(0, 2, 1'b0, 12'h201, 36'h0, t0);
        set_cmd(0, 3, 1'b0, 12'h101, 36'h0, t0);
        for (int k = 0; k < 4; k++) set_cmd(2, k, 1'b1, 12'(12'h100 + k), 36'(36'h100000100 + k), t0);
        drive();
        expect_at(t0 + 3 + RD_LAT, 4'b0001, 36'h100000100, "t5_rd_after_wr");
        repeat (12) tick();

        // Reset with two reads in flight.
        do_reset();
        t0 = cyc;
        set_cmd(0, 0, 1'b0, 12'h010, 36'h0, t0);
        set_cmd(0, 1, 1'b0, 12'h011, 36'h0, t0);
        drive();
        repeat (2) tick();
        rst_n = 1'b0;
        clear_progs();
        drive();
        tick();
        rst_n = 1'b1;
        set_cmd(1, 0, 1'b0, 12'h010, 36'h0, cyc);
        drive();
        expect_at(cyc + 1 + RD_LAT, 4'b0010, 36'h5A5A5A5A5, "t6_rsp");
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
